// File: rtl/mouse_cfg_ctrl_if.sv
// Bus between the mouse configuration sequencer and its environment.
// The slave side is the sequencer itself; the master side drives its inputs.
interface mouse_cfg_ctrl_if;
  logic [11:0] xpos;
  logic        left;
  logic        right;
  logic        cfg_req;
  logic [11:0] value;
  logic        setmax_x;
  logic        setmax_y;
  logic        setx;
  logic        sety;
  logic        cfg_busy;
  logic [11:0] cursor_x;
  logic        left_click;
  logic        right_click;
  logic [11:0] marker_x;

  modport master (
    output xpos, left, right, cfg_req,
    input  value, setmax_x, setmax_y, setx, sety, cfg_busy,
    input  cursor_x, left_click, right_click, marker_x
  );

  modport slave (
    input  xpos, left, right, cfg_req,
    output value, setmax_x, setmax_y, setx, sety, cfg_busy,
    output cursor_x, left_click, right_click, marker_x
  );
endinterface

// File: rtl/mouse_cfg_ctrl.sv
// Programs the mouse controller limits and start position, then clamps the cursor
// and turns button levels into click pulses while running.
module mouse_cfg_ctrl #(
  parameter int MAX_X = 1023,
  parameter int MAX_Y = 767,
  parameter int GAP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mouse_cfg_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    GAP_MAXX, WR_MAXX, GAP_MAXY, WR_MAXY,
    GAP_X,    WR_X,    GAP_Y,    WR_Y,    RUN
  } state_t;

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [11:0] VAL_MAXX = 12'(MAX_X);
  localparam logic [11:0] VAL_MAXY = 12'(MAX_Y);
  localparam logic [11:0] VAL_X    = 12'(MAX_X >> 1);
  localparam logic [11:0] VAL_Y    = 12'(MAX_Y >> 1);

  state_t          r_state;
  logic [CW-1:0]   r_gapCnt;
  logic [11:0]     r_value;
  logic            r_setMaxX, r_setMaxY, r_setX, r_setY;
  logic            r_cfgBusy;
  logic [11:0]     r_cursor;
  logic            r_leftPrev, r_rightPrev;
  logic            r_leftClick, r_rightClick;
  logic [11:0]     r_marker;

  logic w_run, w_inGap, w_gapDone, w_leftEdge, w_rightEdge;

  assign w_run       = (r_state == RUN);
  assign w_inGap     = (r_state == GAP_MAXX) || (r_state == GAP_MAXY) ||
                       (r_state == GAP_X)    || (r_state == GAP_Y);
  assign w_gapDone   = (r_gapCnt == CW'(GAP - 1));
  assign w_leftEdge  = bus.left  & ~r_leftPrev;
  assign w_rightEdge = bus.right & ~r_rightPrev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= GAP_MAXX;
      r_gapCnt     <= '0;
      r_value      <= '0;
      r_setMaxX    <= 1'b0;
      r_setMaxY    <= 1'b0;
      r_setX       <= 1'b0;
      r_setY       <= 1'b0;
      r_cfgBusy    <= 1'b0;
      r_cursor     <= '0;
      r_leftPrev   <= 1'b0;
      r_rightPrev  <= 1'b0;
      r_leftClick  <= 1'b0;
      r_rightClick <= 1'b0;
      r_marker     <= '0;
    end else begin
      r_leftPrev   <= bus.left;
      r_rightPrev  <= bus.right;
      r_cursor     <= (bus.xpos > VAL_MAXX) ? VAL_MAXX : bus.xpos;
      // Button edges only count in RUN; edges seen during a write sequence are dropped.
      r_leftClick  <= w_run & w_leftEdge;
      r_rightClick <= w_run & w_rightEdge;
      if (w_run && w_leftEdge)
        r_marker <= r_cursor;

      r_setMaxX <= 1'b0;
      r_setMaxY <= 1'b0;
      r_setX    <= 1'b0;
      r_setY    <= 1'b0;
      r_gapCnt  <= (w_inGap && !w_gapDone) ? r_gapCnt + 1'b1 : '0;
      if (w_inGap)
        r_cfgBusy <= 1'b1;

      // Value is loaded on entry to each gap so it is stable through gap and strobe.
      case (r_state)
        GAP_MAXX: begin
          r_value <= VAL_MAXX;
          if (w_gapDone) begin
            r_state   <= WR_MAXX;
            r_setMaxX <= 1'b1;
          end
        end
        WR_MAXX: begin
          r_state <= GAP_MAXY;
          r_value <= VAL_MAXY;
        end
        GAP_MAXY: begin
          r_value <= VAL_MAXY;
          if (w_gapDone) begin
            r_state   <= WR_MAXY;
            r_setMaxY <= 1'b1;
          end
        end
        WR_MAXY: begin
          r_state <= GAP_X;
          r_value <= VAL_X;
        end
        GAP_X: begin
          r_value <= VAL_X;
          if (w_gapDone) begin
            r_state <= WR_X;
            r_setX  <= 1'b1;
          end
        end
        WR_X: begin
          r_state <= GAP_Y;
          r_value <= VAL_Y;
        end
        GAP_Y: begin
          r_value <= VAL_Y;
          if (w_gapDone) begin
            r_state <= WR_Y;
            r_setY  <= 1'b1;
          end
        end
        WR_Y: begin
          r_state   <= RUN;
          r_cfgBusy <= 1'b0;
        end
        RUN: begin
          // A full reconfiguration takes priority over a right-click re-centre.
          if (bus.cfg_req) begin
            r_state   <= GAP_MAXX;
            r_value   <= VAL_MAXX;
            r_cfgBusy <= 1'b1;
          end else if (w_rightEdge) begin
            r_state   <= GAP_X;
            r_value   <= VAL_X;
            r_cfgBusy <= 1'b1;
          end
        end
        default: r_state <= GAP_MAXX;
      endcase
    end
  end

  assign bus.value       = r_value;
  assign bus.setmax_x    = r_setMaxX;
  assign bus.setmax_y    = r_setMaxY;
  assign bus.setx        = r_setX;
  assign bus.sety        = r_setY;
  assign bus.cfg_busy    = r_cfgBusy;
  assign bus.cursor_x    = r_cursor;
  assign bus.left_click  = r_leftClick;
  assign bus.right_click = r_rightClick;
  assign bus.marker_x    = r_marker;

endmodule

// File: tb/tb_mouse_cfg_ctrl.sv
// Scoreboard bench for mouse_cfg_ctrl: strobes and clicks are predicted with their
// cycle and bus value when stimulus is driven, then matched as the DUT emits them.
module tb_mouse_cfg_ctrl;

  localparam int MAX_X = 1023;
  localparam int MAX_Y = 767;
  localparam int GAP   = 4;

  // Event kinds seen on the DUT outputs
  localparam int K_MAXX  = 0;
  localparam int K_MAXY  = 1;
  localparam int K_X     = 2;
  localparam int K_Y     = 3;
  localparam int K_LEFT  = 4;
  localparam int K_RIGHT = 5;

  typedef struct {
    int kind;
    int cyc;
    int val;
    bit chkVal;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vecCount;
  int   errCount;
  ev_t  sbQ[$];

  mouse_cfg_ctrl_if bus ();

  mouse_cfg_ctrl #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y),
    .GAP   (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and a cycle counter bumped on every rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int at, input int val, input bit chkVal);
    ev_t e;
    e.kind   = kind;
    e.cyc    = at;
    e.val    = val;
    e.chkVal = chkVal;
    sbQ.push_back(e);
  endtask

  // Predicted full write sequence relative to the last edge that still saw reset/req.
  task automatic pushFullSeq(input int base, input int off);
    pushEv(K_MAXX, base + off + GAP,           MAX_X,      1'b1);
    pushEv(K_MAXY, base + off + 2*GAP + 1,     MAX_Y,      1'b1);
    pushEv(K_X,    base + off + 3*GAP + 2,     MAX_X >> 1, 1'b1);
    pushEv(K_Y,    base + off + 4*GAP + 3,     MAX_Y >> 1, 1'b1);
  endtask

  task automatic handleEvent(input int kind, input int val);
    ev_t e;
    logic hasExp;
    hasExp = (sbQ.size() != 0);
    checkOutput($sformatf("sbExpected_k%0d", kind), 32'(hasExp), 32'd1);
    if (hasExp) begin
      e = sbQ.pop_front();
      checkOutput("evKind", kind, e.kind);
      checkOutput($sformatf("evCycle_k%0d", kind), cyc, e.cyc);
      if (e.chkVal)
        checkOutput($sformatf("evValue_k%0d", kind), val, e.val);
    end
  endtask

  // Output monitor: runs on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("oneStrobe",
                  32'((32'(bus.setmax_x) + 32'(bus.setmax_y) + 32'(bus.setx) + 32'(bus.sety)) > 1),
                  32'd0);
      if (bus.setmax_x)    handleEvent(K_MAXX,  int'(bus.value));
      if (bus.setmax_y)    handleEvent(K_MAXY,  int'(bus.value));
      if (bus.setx)        handleEvent(K_X,     int'(bus.value));
      if (bus.sety)        handleEvent(K_Y,     int'(bus.value));
      if (bus.left_click)  handleEvent(K_LEFT,  int'(bus.marker_x));
      if (bus.right_click) handleEvent(K_RIGHT, 0);
    end
  end

  task automatic waitUntilCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_value"},   32'(bus.value),    32'd0);
    checkOutput({tag, "_strobes"}, 32'({bus.setmax_x, bus.setmax_y, bus.setx, bus.sety}), 32'd0);
    checkOutput({tag, "_busy"},    32'(bus.cfg_busy), 32'd0);
    checkOutput({tag, "_cursor"},  32'(bus.cursor_x), 32'd0);
    checkOutput({tag, "_clicks"},  32'({bus.left_click, bus.right_click}), 32'd0);
    checkOutput({tag, "_marker"},  32'(bus.marker_x), 32'd0);
  endtask

  task automatic applyStimulus();
    int base;
    int c;
    int xin [5];
    int clampExp;
    xin = '{2000, 1023, 1024, 4095, 300};

    rst         = 1'b1;
    bus.xpos    = 12'd500;
    bus.left    = 1'b0;
    bus.right   = 1'b0;
    bus.cfg_req = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");

    // Power-up sequence after reset release
    rst  = 1'b0;
    base = cyc;
    pushFullSeq(base, 0);
    waitUntilCycle(base + 2);
    checkOutput("gapValueMaxX", 32'(bus.value), MAX_X);
    waitUntilCycle(base + 7);
    checkOutput("gapValueMaxY", 32'(bus.value), MAX_Y);
    waitUntilCycle(base + 10);
    checkOutput("busyMidSeq", 32'(bus.cfg_busy), 32'd1);
    waitUntilCycle(base + 19);
    checkOutput("busyAtLastWr", 32'(bus.cfg_busy), 32'd1);
    waitUntilCycle(base + 20);
    checkOutput("busyFall", 32'(bus.cfg_busy), 32'd0);
    checkOutput("valueHeldRun", 32'(bus.value), MAX_Y >> 1);
    checkOutput("drainPowerUp", sbQ.size(), 32'd0);

    // Cursor clamping in RUN
    foreach (xin[i]) begin
      bus.xpos = 12'(xin[i]);
      clampExp = (xin[i] > MAX_X) ? MAX_X : xin[i];
      @(negedge clk);
      checkOutput($sformatf("cursor_%0d", xin[i]), 32'(bus.cursor_x), clampExp);
    end

    // Left click with marker capture; holding the button gives no more pulses
    c = cyc;
    bus.left = 1'b1;
    pushEv(K_LEFT, c + 1, 300, 1'b1);
    repeat (5) @(negedge clk);
    bus.left = 1'b0;
    bus.xpos = 12'd700;
    repeat (2) @(negedge clk);
    c = cyc;
    bus.left = 1'b1;
    pushEv(K_LEFT, c + 1, 700, 1'b1);
    repeat (2) @(negedge clk);
    bus.left = 1'b0;
    @(negedge clk);
    checkOutput("markerHeld", 32'(bus.marker_x), 32'd700);
    checkOutput("drainLeft", sbQ.size(), 32'd0);

    // Right click re-centres with X and Y writes only
    c = cyc;
    bus.right = 1'b1;
    pushEv(K_RIGHT, c + 1, 0, 1'b0);
    pushEv(K_X, c + 1 + GAP, MAX_X >> 1, 1'b1);
    pushEv(K_Y, c + 2 + 2*GAP, MAX_Y >> 1, 1'b1);
    waitUntilCycle(c + 3);
    checkOutput("recentreBusy", 32'(bus.cfg_busy), 32'd1);
    checkOutput("recentreValue", 32'(bus.value), MAX_X >> 1);
    waitUntilCycle(c + 3 + 2*GAP);
    checkOutput("recentreDone", 32'(bus.cfg_busy), 32'd0);
    bus.right = 1'b0;
    @(negedge clk);
    checkOutput("drainRight", sbQ.size(), 32'd0);

    // cfg_req with a right edge: full sequence wins, click still pulses;
    // mid-sequence cfg_req and left edge are ignored
    c = cyc;
    bus.cfg_req = 1'b1;
    bus.right   = 1'b1;
    pushEv(K_RIGHT, c + 1, 0, 1'b0);
    pushFullSeq(c, 1);
    @(negedge clk);
    bus.cfg_req = 1'b0;
    waitUntilCycle(c + 7);
    bus.cfg_req = 1'b1;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    waitUntilCycle(c + 12);
    bus.left = 1'b1;
    waitUntilCycle(c + 4*GAP + 6);
    checkOutput("reqSeqBusy", 32'(bus.cfg_busy), 32'd0);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("drainReq", sbQ.size(), 32'd0);

    // Reset in the middle of GAP_Y abandons the sequence
    c = cyc;
    bus.cfg_req = 1'b1;
    pushEv(K_MAXX, c + 1 + GAP,       MAX_X,      1'b1);
    pushEv(K_MAXY, c + 2 + 2*GAP,     MAX_Y,      1'b1);
    pushEv(K_X,    c + 3 + 3*GAP,     MAX_X >> 1, 1'b1);
    @(negedge clk);
    bus.cfg_req = 1'b0;
    waitUntilCycle(c + 3*GAP + 5);
    checkOutput("drainBeforeRst", sbQ.size(), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midRst");
    rst  = 1'b0;
    base = cyc;
    pushFullSeq(base, 0);
    waitUntilCycle(base + 4*GAP + 5);
    checkOutput("restartBusy", 32'(bus.cfg_busy), 32'd0);
    checkOutput("restartCursor", 32'(bus.cursor_x), 32'd700);
    checkOutput("drainRestart", sbQ.size(), 32'd0);
  endtask

  initial begin
    vecCount = 0;
    errCount = 0;
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
